// File: rtl/multiplicador_pkg.sv
// Shared types and parameter checks for the multiplicador family
// (multiplier today, divider later).
package multiplicador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Valid widths are even and at least 4. Bits per cycle must be 1, 2 or 4
    // and must divide the width.
    function automatic bit legal_bits_per_cycle(input int width, input int bpc);
        return (bpc == 1 || bpc == 2 || bpc == 4) && (width % bpc == 0) &&
               (width >= 4) && (width % 2 == 0);
    endfunction

endpackage

// File: rtl/multiplicador_param_mul_step.sv
// Combinational partial-product adder: acc + mcand * slice, with the
// multiplicand already aligned to the current multiplier bit position.
module mul_step #(
    parameter int ACC_W = 64,
    parameter int BITS  = 1
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] mcand_i,
    input  logic [BITS-1:0]  slice_i,
    output logic [ACC_W-1:0] acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int i = 0; i < BITS; i++) begin
            if (slice_i[i]) acc_o = acc_o + (mcand_i << i);
        end
    end

endmodule

// File: rtl/multiplicador_param.sv
// Sequential shift-add multiplier, unsigned or two's-complement per operation,
// retiring BITS_PER_CYCLE multiplier bits per clock.
module multiplicador_param
    import multiplicador_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 valid_data,
    input  logic                 ack,
    output logic [2*WIDTH-1:0]   producto,
    output logic                 Done_Flag,
    output logic                 busy
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    if (!legal_bits_per_cycle(WIDTH, BITS_PER_CYCLE)) begin : g_bad_param
        $error("multiplicador_param: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 sign_q, sign_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc_step;

    mul_step #(
        .ACC_W (2*WIDTH),
        .BITS  (BITS_PER_CYCLE)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .slice_i (mplier_q[BITS_PER_CYCLE-1:0]),
        .acc_o   (acc_step)
    );

    always_comb begin
        // Magnitude of the most negative value wraps to itself, which is the
        // correct unsigned magnitude 2^(WIDTH-1).
        a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        sign_d   = sign_q;

        case (state_q)
            IDLE: begin
                if (valid_data) begin
                    sign_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    if (a == '0 || b == '0) begin
                        prod_d  = '0;
                        state_d = DONE;
                    end else begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a_mag};
                        mplier_d = b_mag;
                        cnt_d    = CW'(N);
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    prod_d  = sign_q ? -acc_step : acc_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            sign_q   <= sign_d;
        end
    end

    assign producto  = prod_q;
    assign Done_Flag = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule
